// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave endpoint of the inter-FPGA link, system-clock domain
//
// Purpose:
//   Receives fixed-length LSB-first frames from the SPI master and returns a
//   response word on miso within the same frame. sclk, cs and mosi are
//   asynchronous to clk. They are synchronized and edge-detected here.
//   sclk idles high. The master drives mosi and samples miso on sclk rising
//   edges. This slave samples mosi on sclk falling edges.
//
// Ports:
//   clk         system clock, at least 8x the sclk frequency
//   reset       asynchronous active-low reset
//   sclk        SPI clock from master (idles high)
//   cs          chip select from master (active level CS_ACTIVE)
//   mosi        serial data from master
//   miso        serial response to master
//   tx_data     response word, captured when cs goes active
//   rx_data     last correctly received frame
//   rx_valid    one-clk pulse when rx_data is updated
//   frame_error one-clk pulse when a frame ends with a bad bit count
//   busy        high while a frame is in progress

`timescale 1ns/1ps

module spi_slave #(
  parameter int   DATA_WIDTH  = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic CS_ACTIVE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int SW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sclk_d;
  logic                    cs_d;
  logic [SW-1:0]           settle_cnt;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [4:0]              bit_cnt;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic cs_act;
  logic cs_act_d;
  logic sclk_fall;
  logic sclk_rise;
  logic cs_on;
  logic cs_off;

  // All three inputs share one synchronizer depth, so mosi_s is aligned
  // with the sclk edge detect derived from sclk_s.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '1;
      cs_sync   <= {SYNC_STAGES{~CS_ACTIVE}};
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= ~CS_ACTIVE;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_act    = (cs_s == CS_ACTIVE);
  assign cs_act_d  = (cs_d == CS_ACTIVE);
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign cs_on     = cs_act & ~cs_act_d;
  assign cs_off    = ~cs_act & cs_act_d;

  // tx_shift is zero outside a frame, so miso idles low.
  assign miso = tx_shift[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_IDLE;
      settle_cnt  <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        // The cs chain comes out of reset reading inactive even if the pin is
        // active, so require SYNC_STAGES+1 consecutive inactive samples. That
        // outlasts the stale reset contents and keeps a frame that was already
        // running at reset release from being picked up halfway.
        WAIT_IDLE: begin
          busy <= 1'b0;
          if (!cs_act) begin
            if (settle_cnt == SW'(SYNC_STAGES)) begin
              state <= IDLE;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end else begin
            settle_cnt <= '0;
          end
        end

        IDLE: begin
          if (cs_on) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= RECV;
          end
        end

        RECV: begin
          // cs release takes priority. The master's last rising edge lands
          // together with it and is deliberately dropped.
          if (cs_off) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_shift <= '0;
            if (int'(bit_cnt) == DATA_WIDTH) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end else if (sclk_fall) begin
            rx_shift <= {mosi_s, rx_shift[DATA_WIDTH-1:1]};
            if (bit_cnt != 5'd31) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (sclk_rise && bit_cnt != 5'd0) begin
            // The master has just sampled bit k, so present bit k+1.
            tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard testbench for spi_slave

`timescale 1ns/1ps

module tb_spi_slave;

  localparam real CLK_HALF  = 20.833;
  localparam real SCLK_HALF = 208.333;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b1;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = 16'h0000;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [15:0] last_rx = 16'h0000;

  spi_slave #(
    .DATA_WIDTH (16),
    .SYNC_STAGES(2),
    .CS_ACTIVE  (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #(CLK_HALF) clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every rx_valid/frame_error pulse must match the next expected event.
  always @(negedge clk) begin
    if (reset && (rx_valid || frame_error)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: rx_valid=%b frame_error=%b rx_data=%h, expected no event",
                 rx_valid, frame_error, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_valid !== !mon_e.is_err || frame_error !== mon_e.is_err || rx_data !== mon_e.data) begin
          errors++;
          $display("FAIL event: rx_valid=%b frame_error=%b rx_data=%h, expected rx_valid=%b frame_error=%b rx_data=%h",
                   rx_valid, frame_error, rx_data, !mon_e.is_err, mon_e.is_err, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] d, input int nfalls);
    ev_t e;
    if (nfalls == 16) begin
      e.is_err = 1'b0;
      e.data   = d;
      last_rx  = d;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_rx;
    end
    exp_q.push_back(e);
  endtask

  // Master model: mosi set before each falling edge, miso sampled on each rising edge,
  // cs released together with the final rising edge.
  task automatic spi_frame(input logic [15:0] d, input int nfalls, output logic [31:0] cap);
    logic [31:0] dd;
    dd  = {16'h0000, d};
    cap = '0;
    #7;
    cs   = 1'b0;
    mosi = dd[0];
    #(SCLK_HALF);
    for (int i = 0; i < nfalls; i++) begin
      sclk = 1'b0;
      #(SCLK_HALF);
      sclk   = 1'b1;
      cap[i] = miso;
      if (i == nfalls - 1) cs = 1'b1;
      else mosi = dd[i+1];
      #(SCLK_HALF);
    end
    mosi = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx_data: got %h, expected 0000", rx_data); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b, expected 0", frame_error); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, expected 0", miso); end
    reset = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_nominal();
    logic [31:0] cap;
    tx_data = 16'h1234;
    push_exp(16'hA5C3, 16);
    fork
      spi_frame(16'hA5C3, 16, cap);
      begin
        #(8 * SCLK_HALF);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_mid: got %b, expected 1", busy); end
      end
    join
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL nominal_pending: got %0d events outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (cap[15:0] !== 16'h1234) begin errors++; $display("FAIL nominal_miso: got %h, expected 1234", cap[15:0]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_end: got %b, expected 0", busy); end
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL nominal_miso_idle: got %b, expected 0", miso); end
    #(4 * SCLK_HALF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap;
    tx_data = 16'h0F0F;
    push_exp(16'h0001, 16);
    spi_frame(16'h0001, 16, cap);
    #(4 * SCLK_HALF);
    checks++;
    if (rx_data !== 16'h0001) begin errors++; $display("FAIL b2b_first: got %h, expected 0001", rx_data); end
    push_exp(16'hFFFF, 16);
    spi_frame(16'hFFFF, 16, cap);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d events outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (rx_data !== 16'hFFFF) begin errors++; $display("FAIL b2b_second: got %h, expected ffff", rx_data); end
    checks++;
    if (cap[15:0] !== 16'h0F0F) begin errors++; $display("FAIL b2b_miso: got %h, expected 0f0f", cap[15:0]); end
    #(4 * SCLK_HALF);
  endtask

  task automatic test_short_frame();
    logic [31:0] cap;
    push_exp(16'h1111, 9);
    spi_frame(16'h1111, 9, cap);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL short_pending: got %0d events outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (rx_data !== 16'hFFFF) begin errors++; $display("FAIL short_rx_kept: got %h, expected ffff", rx_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b, expected 0", busy); end
    #(4 * SCLK_HALF);
    push_exp(16'h3C96, 16);
    spi_frame(16'h3C96, 16, cap);
    wait_drain();
    checks++;
    if (rx_data !== 16'h3C96) begin errors++; $display("FAIL short_recover: got %h, expected 3c96", rx_data); end
    #(4 * SCLK_HALF);
  endtask

  task automatic test_long_frame();
    logic [31:0] cap;
    tx_data = 16'h8001;
    push_exp(16'h7777, 17);
    spi_frame(16'h7777, 17, cap);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL long_pending: got %0d events outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (cap[16:0] !== 17'h08001) begin errors++; $display("FAIL long_miso: got %h, expected 08001", cap[16:0]); end
    checks++;
    if (rx_data !== 16'h3C96) begin errors++; $display("FAIL long_rx_kept: got %h, expected 3c96", rx_data); end
    #(4 * SCLK_HALF);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] cap;
    logic [15:0] d;
    d = 16'hC3A5;
    #7;
    cs   = 1'b0;
    mosi = d[0];
    #(SCLK_HALF);
    for (int i = 0; i < 16; i++) begin
      sclk = 1'b0;
      #(SCLK_HALF);
      if (i == 5) begin
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        checks++;
        if (rx_data !== 16'h0000) begin errors++; $display("FAIL midreset_rx_data: got %h, expected 0000", rx_data); end
        last_rx = 16'h0000;
        #(3 * 2 * CLK_HALF);
        reset = 1'b1;
      end
      sclk = 1'b1;
      if (i == 15) cs = 1'b1;
      else mosi = d[i+1];
      #(SCLK_HALF);
    end
    mosi = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (rx_data !== 16'h0000) begin errors++; $display("FAIL midreset_ignored: got %h, expected 0000", rx_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after: got %b, expected 0", busy); end
    push_exp(16'h5A5A, 16);
    spi_frame(16'h5A5A, 16, cap);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_pending: got %0d events outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (rx_data !== 16'h5A5A) begin errors++; $display("FAIL midreset_next: got %h, expected 5a5a", rx_data); end
    #(4 * SCLK_HALF);
  endtask

  task automatic test_tx_change();
    logic [31:0] cap;
    tx_data = 16'h00FF;
    push_exp(16'h1357, 16);
    fork
      spi_frame(16'h1357, 16, cap);
      begin
        #(6 * SCLK_HALF);
        tx_data = 16'hBEEF;
      end
    join
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL txchg_pending: got %0d events outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    checks++;
    if (cap[15:0] !== 16'h00FF) begin errors++; $display("FAIL txchg_miso: got %h, expected 00ff", cap[15:0]); end
    checks++;
    if (rx_data !== 16'h1357) begin errors++; $display("FAIL txchg_rx: got %h, expected 1357", rx_data); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_tx_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Receiving end of the inter-FPGA SPI link. It consumes the 16-bit frames the SPI master produces and returns a response word on miso in the same frame.
- Runs entirely on the local system clock. sclk, cs and mosi are asynchronous inputs, synchronized and edge-detected internally.
- Link format is fixed by the master:
  - sclk idles high.
  - Master changes mosi and samples miso on sclk rising edges.
  - Slave samples mosi on sclk falling edges.
  - LSB first, 16 bits per cs assertion.

Parameters:
- DATA_WIDTH, 16, frame length in bits.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs and mosi (minimum 2).
- CS_ACTIVE, 1'b0, active level of cs (0 = active low).

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from master; idles high.
- cs  input  1  chip select from master.
- mosi  input  1  serial data from master.
- miso  output  1  serial response to master.
- tx_data  input  DATA_WIDTH  response word; captured when cs goes active.
- rx_data  output  DATA_WIDTH  last correctly received frame.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- frame_error  output  1  one-clk pulse when a frame ends with a bit count other than DATA_WIDTH.
- busy  output  1  high while a frame is in progress (state RECV).

Behaviour:
- Reset (reset=0, asynchronous) values:
  - rx_data=0, rx_valid=0, frame_error=0, busy=0, miso=0.
  - Internal: tx_shift=0, rx_shift=0, bit_cnt=0.
  - sclk synchronizer chain =1; cs chain = !CS_ACTIVE.
  - State goes to WAIT_IDLE.
- Edge detection: compare the last synchronizer stage against a registered copy. One detect pulse per edge. Synchronized mosi has the same depth as sclk, so it is aligned with the sclk edge detect.
- States:
  - WAIT_IDLE: stay until synchronized cs is inactive, then go to IDLE. A frame already in progress when reset releases is ignored entirely.
  - IDLE: on cs active edge:
    - tx_shift <= tx_data, rx_shift <= 0, bit_cnt <= 0, busy <= 1, go to RECV.
    - miso = tx_shift[0] from the next clk, so bit0 is valid well before the master's first sample.
    - sclk edges are ignored in IDLE.
  - RECV, sclk falling edge: rx_shift <= {mosi_s, rx_shift[DATA_WIDTH-1:1]}; bit_cnt <= bit_cnt+1, saturating at 31 (5-bit counter).
  - RECV, sclk rising edge with bit_cnt>0: tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]}, presenting bit k+1 after the master has sampled bit k. Rising edges with bit_cnt=0 are ignored.
  - RECV, cs inactive edge: go to IDLE, busy <= 0.
    - If bit_cnt==DATA_WIDTH: rx_data <= rx_shift, rx_valid=1 for exactly one clk.
    - Otherwise: frame_error=1 for one clk; rx_data unchanged.
- Latency: rx_valid/frame_error assert on the clk after the cs inactive edge is detected, at most SYNC_STAGES+2 clk after cs changes at the pin.
- Simultaneous events:
  - cs inactive edge and sclk edge detected in the same clk: cs wins, the sclk edge is discarded. The master's final rising edge coincides with cs release and is harmless.
  - cs active edge and sclk edge in the same clk: cs wins.
- Over-length frame (more than DATA_WIDTH falling edges): bit_cnt exceeds DATA_WIDTH, giving frame_error at cs release. miso shifts in 0s after the response word is exhausted.
- tx_data is sampled only at frame start. Changes during RECV do not affect the current frame.
- miso outside RECV is held at 0 (tx_shift cleared on cs inactive edge).
- rx_valid and frame_error are never high in the same clk.

Test Plan:
- Nominal frame: clk 24 MHz, sclk 2.4 MHz. Master sends 16'hA5C3 LSB first with tx_data=16'h1234 → rx_data=16'hA5C3, one rx_valid pulse, master-side capture equals 16'h1234, frame_error stays 0.
- Back-to-back frames 16'h0001 then 16'hFFFF, 2 sclk periods of cs high between them → two rx_valid pulses; rx_data shows 16'h0001, then 16'hFFFF.
- Short frame: cs released after 9 falling edges → frame_error pulse, rx_data keeps its previous value, busy drops, next full frame received correctly.
- Long frame: 17 falling edges → frame_error pulse, no rx_valid.
- Reset mid-frame: assert reset after 5 bits, release while cs is still active → no rx_valid or frame_error for that frame; a following complete frame 16'h5A5A yields rx_valid with rx_data=16'h5A5A.
- tx_data changed to 16'hBEEF mid-frame after being 16'h00FF at cs fall → master receives 16'h00FF.
